// File: rtl/tnn_feature_packer_if.sv
// ============================================================================
// tnn_feature_packer_if : feature stream in, packed comparator frame out
// Rev 1.0
// ============================================================================
`default_nettype none

interface tnn_feature_packer_if #(
  parameter int IN_W  = 8,
  parameter int QW    = 3,
  parameter int NFEAT = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [NFEAT*QW-1:0]   out_frame;
  logic                  out_short;
  logic                  err_overrun;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_frame, out_short, err_overrun
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_frame, out_short, err_overrun
  );
endinterface

`default_nettype wire

// File: rtl/tnn_feature_packer.sv
// ============================================================================
// tnn_feature_packer : quantises 8-bit features, packs six into an 18-bit frame
// Optional: TNN_PACK_ROUND_EN selects round-to-nearest with saturation.
// Rev 1.0
// ============================================================================
`default_nettype none

module tnn_feature_packer #(
  parameter int IN_W  = 8,
  parameter int QW    = 3,
  parameter int NFEAT = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tnn_feature_packer_if.slave  bus
);

  localparam int FW = NFEAT * QW;
  localparam int IW = (NFEAT > 1) ? $clog2(NFEAT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NFEAT - 1);

  logic [FW-1:0] asm_q, asm_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          pend_q, pend_d;
  logic [FW-1:0] pend_frame_q, pend_frame_d;
  logic          pend_short_q, pend_short_d;
  logic          out_valid_q, out_valid_d;
  logic [FW-1:0] out_frame_q, out_frame_d;
  logic          out_short_q, out_short_d;
  logic          err_q, err_d;
  logic          in_ready_q, in_ready_d;

  logic [QW-1:0] q;
  logic [FW-1:0] wr_frame;
  logic          accept, at_last, close, out_free;

`ifdef TNN_PACK_ROUND_EN
  localparam logic [IN_W:0] HALF = (IN_W+1)'(1) << (IN_W - QW - 1);
  logic [IN_W:0] sum;
  logic [IN_W:0] shr;

  always_comb begin
    sum = {1'b0, bus.in_data} + HALF;
    shr = sum >> (IN_W - QW);
    q   = (|shr[IN_W:QW]) ? {QW{1'b1}} : shr[QW-1:0];
  end
`else
  assign q = bus.in_data[IN_W-1 -: QW];
`endif

  assign accept   = bus.in_valid & in_ready_q;
  assign at_last  = (idx_q == LAST_IDX);
  assign close    = accept & (bus.in_last | at_last);
  assign out_free = ~out_valid_q | bus.out_ready;

  // Unwritten fields stay zero because the assembly register clears on close.
  always_comb begin
    wr_frame = asm_q;
    for (int k = 0; k < NFEAT; k++) begin
      if (idx_q == IW'(k)) wr_frame[k*QW +: QW] = q;
    end
  end

  always_comb begin
    asm_d        = asm_q;
    idx_d        = idx_q;
    pend_d       = pend_q;
    pend_frame_d = pend_frame_q;
    pend_short_d = pend_short_q;
    out_valid_d  = out_valid_q;
    out_frame_d  = out_frame_q;
    out_short_d  = out_short_q;
    err_d        = err_q;

    if (accept) begin
      if (close) begin
        asm_d = '0;
        idx_d = '0;
      end else begin
        asm_d = wr_frame;
        idx_d = idx_q + 1'b1;
      end
    end

    if (close && at_last && !bus.in_last) err_d = 1'b1;

    // A pending frame can only exist while in_ready is low, so it never races a close.
    if (out_free) begin
      if (pend_q) begin
        out_valid_d = 1'b1;
        out_frame_d = pend_frame_q;
        out_short_d = pend_short_q;
        pend_d      = 1'b0;
      end else if (close) begin
        out_valid_d = 1'b1;
        out_frame_d = wr_frame;
        out_short_d = ~at_last;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (close) begin
      pend_d       = 1'b1;
      pend_frame_d = wr_frame;
      pend_short_d = ~at_last;
    end

    in_ready_d = ~pend_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      asm_q        <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      pend_frame_q <= '0;
      pend_short_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_frame_q  <= '0;
      out_short_q  <= 1'b0;
      err_q        <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      asm_q        <= asm_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_frame_q <= pend_frame_d;
      pend_short_q <= pend_short_d;
      out_valid_q  <= out_valid_d;
      out_frame_q  <= out_frame_d;
      out_short_q  <= out_short_d;
      err_q        <= err_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_frame   = out_frame_q;
  assign bus.out_short   = out_short_q;
  assign bus.err_overrun = err_q;

endmodule

`default_nettype wire

// File: tb/tb_tnn_feature_packer.sv
// ============================================================================
// tb_tnn_feature_packer : directed self-checking bench for tnn_feature_packer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tnn_feature_packer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  tnn_feature_packer_if #(.IN_W(8), .QW(3), .NFEAT(6)) bus ();

  tnn_feature_packer #(.IN_W(8), .QW(3), .NFEAT(6)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 'o%0o expected 'o%0o", tag, act, exp);
    end
  endtask

  // Hold the feature until the packer takes it; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic last);
    logic r;
    int   n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    n = 0;
    do begin
      r = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 50);
    if (!r) check("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send6(input logic [47:0] vals, input logic last6);
    for (int k = 0; k < 6; k++) send(vals[k*8 +: 8], (k == 5) ? last6 : 1'b0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),    32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid),   32'd0);
    check({tag, "_out_frame"}, 32'(bus.out_frame),   32'd0);
    check({tag, "_out_short"}, 32'(bus.out_short),   32'd0);
    check({tag, "_err"},       32'(bus.err_overrun), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) tick();
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick();
    check("rst_release_in_ready", 32'(bus.in_ready), 32'd1);

    // Full frame, truncation: 0x00,0x20,0x40,0x60,0x80,0xFF
    send6({8'hFF, 8'h80, 8'h60, 8'h40, 8'h20, 8'h00}, 1'b1);
    check("full_valid", 32'(bus.out_valid), 32'd1);
    check("full_frame", 32'(bus.out_frame), 32'o743210);
    check("full_short", 32'(bus.out_short), 32'd0);
    tick();
    check("full_drained", 32'(bus.out_valid), 32'd0);

    // Rounding vectors: 0x0F,0x10,0xEF,0xF0,0xFF,0x30
    send6({8'h30, 8'hFF, 8'hF0, 8'hEF, 8'h10, 8'h0F}, 1'b1);
`ifdef TNN_PACK_ROUND_EN
    check("round_frame", 32'(bus.out_frame), 32'o277710);
`else
    check("round_frame", 32'(bus.out_frame), 32'o177700);
`endif
    tick();

    // Short frame then a full frame to confirm the index restarted at 0.
    send(8'h60, 1'b0);
    send(8'hA0, 1'b1);
    check("short_valid", 32'(bus.out_valid), 32'd1);
    check("short_frame", 32'(bus.out_frame), 32'o000053);
    check("short_flag",  32'(bus.out_short), 32'd1);
    check("short_err",   32'(bus.err_overrun), 32'd0);
    send6({8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'hE0}, 1'b1);
    check("after_short_frame", 32'(bus.out_frame), 32'o234567);
    check("after_short_flag",  32'(bus.out_short), 32'd0);
    tick();

    // Backpressure: 12 features with the consumer stalled.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      send(8'(i * 32), (i == 5 || i == 11));
      if (i >= 5) check("bp_hold_frame", 32'(bus.out_frame), 32'o543210);
    end
    check("bp_in_ready_low", 32'(bus.in_ready),  32'd0);
    check("bp_valid",        32'(bus.out_valid), 32'd1);
    tick();
    check("bp_still_held",   32'(bus.out_frame), 32'o543210);
    check("bp_still_low",    32'(bus.in_ready),  32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_second_valid", 32'(bus.out_valid), 32'd1);
    check("bp_second_frame", 32'(bus.out_frame), 32'o321076);
    check("bp_second_short", 32'(bus.out_short), 32'd0);
    check("bp_in_ready_up",  32'(bus.in_ready),  32'd1);
    tick();
    check("bp_second_held",  32'(bus.out_frame), 32'o321076);
    bus.out_ready = 1'b1;
    tick();
    check("bp_drained",      32'(bus.out_valid), 32'd0);

    // Overrun: six features without in_last, then a good frame.
    send6({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1'b0);
    check("ovr_frame", 32'(bus.out_frame),   32'o777777);
    check("ovr_short", 32'(bus.out_short),   32'd0);
    check("ovr_err",   32'(bus.err_overrun), 32'd1);
    send6({8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20}, 1'b1);
    check("ovr_good_frame", 32'(bus.out_frame),   32'o111111);
    check("ovr_sticky",     32'(bus.err_overrun), 32'd1);
    tick();

    // Reset in the middle of a frame.
    send(8'hE0, 1'b0);
    send(8'hE0, 1'b0);
    send(8'hE0, 1'b0);
    rst_n = 1'b0;
    tick();
    check_reset_vals("midrst");
    rst_n = 1'b1;
    tick();
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    check("midrst_no_early", 32'(bus.out_valid), 32'd0);
    send(8'h20, 1'b0);
    send(8'h20, 1'b0);
    send(8'h20, 1'b1);
    check("midrst_valid", 32'(bus.out_valid),   32'd1);
    check("midrst_frame", 32'(bus.out_frame),   32'o111000);
    check("midrst_short", 32'(bus.out_short),   32'd0);
    check("midrst_err",   32'(bus.err_overrun), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
